regfile_wb_sched: RTL and testbench

Writeback scheduler and scoreboard for the 32x32 register file. It shares the single register-file write port between three writeback requesters: ALU result, load data and jump link address. It drives the `RegWrite`, `rd`, `writeData`, `jump_enb` and `pc_out` inputs of the register file from one registered port. It also keeps a per-register count of in-flight writes so the issue stage can detect RAW hazards on rs1/rs2 and refuse to issue past the count limit.

---
 rtl/regfile_wb_sched.sv | 172 +++++++++++++++++
 tb/tb_regfile_wb_sched.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_sched.sv
// regfile_wb_sched -- writeback scheduler and pending-write scoreboard for
// the 32x32 register file.
//
// Three writeback requesters (ALU result, load data, jump link) share the
// single register-file write port. One requester is granted per cycle and
// its writeback is registered onto the wb_* port one edge later. A per-
// register counter of in-flight writes feeds RAW hazard detection and
// issue back-pressure.
//
// Optional feature: define WB_FIXED_PRIO_EN for fixed priority
// load > ALU > link instead of the default round robin ALU -> load -> link.
//
// Ports:
//   clk, rst_n                        clock, async active-low reset
//   alu_valid/alu_ready, alu_rd, alu_data
//   ld_valid/ld_ready,   ld_rd,  ld_data
//   lnk_valid/lnk_ready, lnk_rd, lnk_pc       writeback requesters
//   iss_valid, iss_rd, iss_ready      issue-stage write announcement
//   rs1, rs2, hazard1, hazard2        source hazard lookup (combinational)
//   wb_we, wb_rd, wb_data, wb_jump_enb, wb_pc  register-file write port
module regfile_wb_sched #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              alu_valid,
  output logic              alu_ready,
  input  logic [4:0]        alu_rd,
  input  logic [DATA_W-1:0] alu_data,
  input  logic              ld_valid,
  output logic              ld_ready,
  input  logic [4:0]        ld_rd,
  input  logic [DATA_W-1:0] ld_data,
  input  logic              lnk_valid,
  output logic              lnk_ready,
  input  logic [4:0]        lnk_rd,
  input  logic [DATA_W-1:0] lnk_pc,
  input  logic              iss_valid,
  input  logic [4:0]        iss_rd,
  output logic              iss_ready,
  input  logic [4:0]        rs1,
  input  logic [4:0]        rs2,
  output logic              hazard1,
  output logic              hazard2,
  output logic              wb_we,
  output logic [4:0]        wb_rd,
  output logic [DATA_W-1:0] wb_data,
  output logic              wb_jump_enb,
  output logic [DATA_W-1:0] wb_pc
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  // grant vector bit order: [0]=ALU, [1]=load, [2]=link
  logic [2:0] gnt;

`ifdef WB_FIXED_PRIO_EN
  always_comb begin
    gnt = 3'b000;
    if (ld_valid)       gnt = 3'b010;
    else if (alu_valid) gnt = 3'b001;
    else if (lnk_valid) gnt = 3'b100;
  end
`else
  logic [1:0] ptr_q, ptr_d;

  // Search order starts at the pointer and wraps ALU -> load -> link.
  always_comb begin
    gnt = 3'b000;
    case (ptr_q)
      2'd1: begin
        if (ld_valid)       gnt = 3'b010;
        else if (lnk_valid) gnt = 3'b100;
        else if (alu_valid) gnt = 3'b001;
      end
      2'd2: begin
        if (lnk_valid)      gnt = 3'b100;
        else if (alu_valid) gnt = 3'b001;
        else if (ld_valid)  gnt = 3'b010;
      end
      default: begin
        if (alu_valid)      gnt = 3'b001;
        else if (ld_valid)  gnt = 3'b010;
        else if (lnk_valid) gnt = 3'b100;
      end
    endcase
  end

  always_comb begin
    ptr_d = ptr_q;
    if (gnt[0])      ptr_d = 2'd1;
    else if (gnt[1]) ptr_d = 2'd2;
    else if (gnt[2]) ptr_d = 2'd0;
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) ptr_q <= 2'd0;
    else        ptr_q <= ptr_d;
`endif

  assign alu_ready = gnt[0];
  assign ld_ready  = gnt[1];
  assign lnk_ready = gnt[2];

  // Writeback output register
  logic              we_q, we_d, jmp_q, jmp_d;
  logic [4:0]        rd_q, rd_d;
  logic [DATA_W-1:0] data_q, data_d, pc_q, pc_d;

  always_comb begin
    we_d   = 1'b0;
    rd_d   = rd_q;
    data_d = data_q;
    jmp_d  = jmp_q;
    pc_d   = pc_q;
    if (gnt[0]) begin
      rd_d = alu_rd; data_d = alu_data; jmp_d = 1'b0;
    end else if (gnt[1]) begin
      rd_d = ld_rd;  data_d = ld_data;  jmp_d = 1'b0;
    end else if (gnt[2]) begin
      rd_d = lnk_rd; data_d = '0;       jmp_d = 1'b1; pc_d = lnk_pc;
    end
    // rd=0 requests are consumed without producing a write
    if (gnt != 3'b000) we_d = (rd_d != 5'd0);
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      we_q <= 1'b0; rd_q <= '0; data_q <= '0; jmp_q <= 1'b0; pc_q <= '0;
    end else begin
      we_q <= we_d; rd_q <= rd_d; data_q <= data_d; jmp_q <= jmp_d; pc_q <= pc_d;
    end

  assign wb_we       = we_q;
  assign wb_rd       = rd_q;
  assign wb_data     = data_q;
  assign wb_jump_enb = jmp_q;
  assign wb_pc       = pc_q;

  // Scoreboard: decrement follows the registered write so it lands on the
  // same edge the register file captures the data.
  logic [CNT_W-1:0] cnt_q [32];
  logic [CNT_W-1:0] cnt_d [32];
  logic             iss_acc, commit_iss;

  assign commit_iss = we_q && (rd_q == iss_rd);
  assign iss_ready  = (iss_rd == 5'd0) || (cnt_q[iss_rd] != CNT_MAX) || commit_iss;
  assign iss_acc    = iss_valid && iss_ready && (iss_rd != 5'd0);
  assign hazard1    = (rs1 != 5'd0) && (cnt_q[rs1] != '0);
  assign hazard2    = (rs2 != 5'd0) && (cnt_q[rs2] != '0);

  always_comb begin
    for (int r = 0; r < 32; r++) begin
      cnt_d[r] = cnt_q[r];
      if (r != 0) begin
        if (iss_acc && (iss_rd == 5'(r)) && !(we_q && (rd_q == 5'(r))))
          cnt_d[r] = cnt_q[r] + 1'b1;
        else if (we_q && (rd_q == 5'(r)) && !(iss_acc && (iss_rd == 5'(r)))
                 && (cnt_q[r] != '0))
          cnt_d[r] = cnt_q[r] - 1'b1;
      end else begin
        cnt_d[r] = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) for (int r = 0; r < 32; r++) cnt_q[r] <= '0;
    else        for (int r = 0; r < 32; r++) cnt_q[r] <= cnt_d[r];

endmodule

// File: tb/tb_regfile_wb_sched.sv
module tb_regfile_wb_sched;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        alu_valid, ld_valid, lnk_valid, iss_valid;
  logic        alu_ready, ld_ready, lnk_ready, iss_ready;
  logic [4:0]  alu_rd, ld_rd, lnk_rd, iss_rd, rs1, rs2, wb_rd;
  logic [31:0] alu_data, ld_data, lnk_pc, wb_data, wb_pc;
  logic        hazard1, hazard2, wb_we, wb_jump_enb;
  int          n_tests = 0;
  int          n_fail  = 0;

  always #5 clk = ~clk;

  regfile_wb_sched #(.DATA_W(32), .CNT_W(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_rd(ld_rd), .ld_data(ld_data),
    .lnk_valid(lnk_valid), .lnk_ready(lnk_ready), .lnk_rd(lnk_rd), .lnk_pc(lnk_pc),
    .iss_valid(iss_valid), .iss_rd(iss_rd), .iss_ready(iss_ready),
    .rs1(rs1), .rs2(rs2), .hazard1(hazard1), .hazard2(hazard2),
    .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
    .wb_jump_enb(wb_jump_enb), .wb_pc(wb_pc)
  );

  // Inputs change 1 time unit after a rising edge; checks follow 1 unit later.
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    alu_valid = 0; ld_valid = 0; lnk_valid = 0; iss_valid = 0;
    alu_rd = 0; ld_rd = 0; lnk_rd = 0; iss_rd = 0; rs1 = 0; rs2 = 0;
    alu_data = 0; ld_data = 0; lnk_pc = 0;
    #2 rst_n = 1'b1;
    tick();
  endtask

  task automatic issue(input logic [4:0] rd);
    iss_valid = 1; iss_rd = rd;
    tick();
    iss_valid = 0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0; iss_rd = 5'd5; rs1 = 5'd5; rs2 = 5'd5;
    alu_valid = 0; ld_valid = 0; lnk_valid = 0; iss_valid = 0;
    #1;
    n_tests++;
    if ({wb_we, wb_rd, wb_data, wb_jump_enb, wb_pc} !== '0) begin
      $display("FAIL reset_wb: got we=%b rd=%0d data=%h j=%b pc=%h, want all 0",
               wb_we, wb_rd, wb_data, wb_jump_enb, wb_pc); n_fail++;
    end
    n_tests++;
    if (iss_ready !== 1'b1 || hazard1 !== 1'b0 || hazard2 !== 1'b0) begin
      $display("FAIL reset_sb: got iss_ready=%b hz1=%b hz2=%b, want 1 0 0",
               iss_ready, hazard1, hazard2); n_fail++;
    end
    #1 rst_n = 1'b1;
    tick();
    issue(5'd5);
    alu_valid = 1; alu_rd = 5'd5; alu_data = 32'h1234;
    #1;
    n_tests++;
    if (alu_ready !== 1'b1) begin
      $display("FAIL reset_alu_ready: got %b want 1", alu_ready); n_fail++;
    end
    tick();
    alu_valid = 0;
    #1;
    n_tests++;
    if (wb_we !== 1'b1 || wb_rd !== 5'd5 || wb_data !== 32'h1234 || wb_jump_enb !== 1'b0) begin
      $display("FAIL first_wb: got we=%b rd=%0d data=%h j=%b, want 1 5 00001234 0",
               wb_we, wb_rd, wb_data, wb_jump_enb); n_fail++;
    end
    tick(); #1;
    n_tests++;
    if (wb_we !== 1'b0 || hazard1 !== 1'b0) begin
      $display("FAIL first_wb_after: got we=%b hz1=%b, want 0 0", wb_we, hazard1); n_fail++;
    end
  endtask

  task automatic test_contention();
    int order [3];
    logic [31:0] exp_data [3];
    int g;
`ifdef WB_FIXED_PRIO_EN
    order = '{1, 0, 2};
`else
    order = '{0, 1, 2};
`endif
    exp_data = '{32'hA0A0, 32'hB0B0, 32'h0};
    do_reset();
    issue(5'd1); issue(5'd2); issue(5'd3);
    alu_valid = 1; alu_rd = 5'd1; alu_data = 32'hA0A0;
    ld_valid  = 1; ld_rd  = 5'd2; ld_data  = 32'hB0B0;
    lnk_valid = 1; lnk_rd = 5'd3; lnk_pc   = 32'h100;
    for (int k = 0; k < 3; k++) begin
      g = order[k];
      #1;
      n_tests++;
      if ({lnk_ready, ld_ready, alu_ready} !== 3'(1 << g)) begin
        $display("FAIL cont_grant%0d: got %b want %b", k,
                 {lnk_ready, ld_ready, alu_ready}, 3'(1 << g)); n_fail++;
      end
      tick();
      if (g == 0) alu_valid = 0;
      if (g == 1) ld_valid  = 0;
      if (g == 2) lnk_valid = 0;
      #1;
      n_tests++;
      if (wb_we !== 1'b1 || wb_rd !== 5'(g + 1) || wb_data !== exp_data[g]
          || wb_jump_enb !== (g == 2)) begin
        $display("FAIL cont_wb%0d: got we=%b rd=%0d data=%h j=%b, want 1 %0d %h %b", k,
                 wb_we, wb_rd, wb_data, wb_jump_enb, g + 1, exp_data[g], g == 2); n_fail++;
      end
      if (g == 2) begin
        n_tests++;
        if (wb_pc !== 32'h100 || wb_pc + 32'd4 !== 32'h104) begin
          $display("FAIL cont_link_pc: got %h want 00000100 (regfile 00000104)", wb_pc); n_fail++;
        end
      end
    end
    tick(); tick();
    rs1 = 5'd3; rs2 = 5'd1; #1;
    n_tests++;
    if (hazard1 !== 1'b0 || hazard2 !== 1'b0 || wb_we !== 1'b0) begin
      $display("FAIL cont_drain: got hz1=%b hz2=%b we=%b want 0 0 0",
               hazard1, hazard2, wb_we); n_fail++;
    end
  endtask

  task automatic test_scoreboard();
    do_reset();
    rs1 = 5'd7;
    for (int k = 0; k < 3; k++) begin
      iss_valid = 1; iss_rd = 5'd7; #1;
      n_tests++;
      if (iss_ready !== 1'b1) begin
        $display("FAIL sb_issue%0d: got iss_ready=%b want 1", k, iss_ready); n_fail++;
      end
      tick();
    end
    iss_valid = 0; iss_rd = 5'd7; #1;
    n_tests++;
    if (hazard1 !== 1'b1 || iss_ready !== 1'b0) begin
      $display("FAIL sb_full: got hz1=%b iss_ready=%b want 1 0", hazard1, iss_ready); n_fail++;
    end
    alu_valid = 1; alu_rd = 5'd7; alu_data = 32'h77;
    tick();
    alu_valid = 0; #1;
    n_tests++;
    if (wb_we !== 1'b1 || wb_rd !== 5'd7 || iss_ready !== 1'b1) begin
      $display("FAIL sb_commit_bypass: got we=%b rd=%0d iss_ready=%b want 1 7 1",
               wb_we, wb_rd, iss_ready); n_fail++;
    end
    tick(); #1;
    n_tests++;
    if (iss_ready !== 1'b1 || hazard1 !== 1'b1 || wb_we !== 1'b0) begin
      $display("FAIL sb_cnt2: got iss_ready=%b hz1=%b we=%b want 1 1 0",
               iss_ready, hazard1, wb_we); n_fail++;
    end
  endtask

  task automatic test_same_cycle();
    do_reset();
    rs2 = 5'd3;
    issue(5'd3);
    alu_valid = 1; alu_rd = 5'd3; alu_data = 32'h33;
    tick();
    alu_valid = 0;
    iss_valid = 1; iss_rd = 5'd3; #1;
    n_tests++;
    if (wb_we !== 1'b1 || iss_ready !== 1'b1 || hazard2 !== 1'b1) begin
      $display("FAIL same_cycle_pre: got we=%b iss_ready=%b hz2=%b want 1 1 1",
               wb_we, iss_ready, hazard2); n_fail++;
    end
    tick();
    iss_valid = 0; #1;
    n_tests++;
    if (hazard2 !== 1'b1) begin
      $display("FAIL same_cycle_cnt1: got hz2=%b want 1", hazard2); n_fail++;
    end
    // a single further commit must bring the count from 1 to 0
    ld_valid = 1; ld_rd = 5'd3; ld_data = 32'h44;
    tick();
    ld_valid = 0;
    tick(); #1;
    n_tests++;
    if (hazard2 !== 1'b0) begin
      $display("FAIL same_cycle_drain: got hz2=%b want 0", hazard2); n_fail++;
    end
  endtask

  task automatic test_rd0();
    do_reset();
    lnk_valid = 1; lnk_rd = 5'd0; lnk_pc = 32'h200; #1;
    n_tests++;
    if (lnk_ready !== 1'b1) begin
      $display("FAIL rd0_ready: got %b want 1", lnk_ready); n_fail++;
    end
    tick();
    lnk_valid = 0;
    iss_valid = 1; iss_rd = 5'd0; rs1 = 5'd0; rs2 = 5'd0; #1;
    n_tests++;
    if (wb_we !== 1'b0 || hazard1 !== 1'b0 || hazard2 !== 1'b0 || iss_ready !== 1'b1) begin
      $display("FAIL rd0_nowrite: got we=%b hz1=%b hz2=%b iss_ready=%b want 0 0 0 1",
               wb_we, hazard1, hazard2, iss_ready); n_fail++;
    end
    tick();
    iss_valid = 0; #1;
    n_tests++;
    if (wb_we !== 1'b0 || hazard1 !== 1'b0) begin
      $display("FAIL rd0_after: got we=%b hz1=%b want 0 0", wb_we, hazard1); n_fail++;
    end
    // pointer moved past link back to ALU: ALU wins over load
    alu_valid = 1; ld_valid = 1; alu_rd = 0; ld_rd = 0; #1;
    n_tests++;
`ifdef WB_FIXED_PRIO_EN
    if ({ld_ready, alu_ready} !== 2'b10) begin
`else
    if ({ld_ready, alu_ready} !== 2'b01) begin
`endif
      $display("FAIL rd0_ptr: got ld/alu ready=%b%b", ld_ready, alu_ready); n_fail++;
    end
    alu_valid = 0; ld_valid = 0;
  endtask

  task automatic test_mid_reset();
    do_reset();
    rs1 = 5'd9;
    issue(5'd9);
    alu_valid = 1; alu_rd = 5'd9; alu_data = 32'h99;
    tick();
    alu_valid = 0;
    rst_n = 1'b0; #1;
    n_tests++;
    if (wb_we !== 1'b0 || wb_rd !== 5'd0 || wb_data !== 32'h0) begin
      $display("FAIL midrst_async: got we=%b rd=%0d data=%h want 0 0 0",
               wb_we, wb_rd, wb_data); n_fail++;
    end
    #1 rst_n = 1'b1;
    tick(); #1;
    n_tests++;
    if (wb_we !== 1'b0 || hazard1 !== 1'b0) begin
      $display("FAIL midrst_after: got we=%b hz1(cnt9)=%b want 0 0", wb_we, hazard1); n_fail++;
    end
  endtask

  initial begin
    rst_n = 1'b1;
    alu_valid = 0; ld_valid = 0; lnk_valid = 0; iss_valid = 0;
    alu_rd = 0; ld_rd = 0; lnk_rd = 0; iss_rd = 0; rs1 = 0; rs2 = 0;
    alu_data = 0; ld_data = 0; lnk_pc = 0;
    test_reset();
    test_contention();
    test_scoreboard();
    test_same_cycle();
    test_rd0();
    test_mid_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, got running want done");
    $fatal(1);
  end
endmodule
